// File: rtl/cpu_fsm_table_ctrl_if.sv
// CPU register port and overlay FSM symbol/state signals for cpu_fsm_table_ctrl.
// master = CPU/bus-decoder side, slave = the controller.
interface cpu_fsm_table_ctrl_if #(
    parameter int STATE_W = 2,
    parameter int IN_W    = 2,
    parameter int OUT_W   = 4
);
    logic [2:0]         cpu_addr;
    logic [31:0]        cpu_data_in;
    logic               cpu_write_enable;
    logic               cpu_read_enable;
    logic [31:0]        cpu_data_out;
    logic               cpu_rvalid;
    logic [IN_W-1:0]    fsm_in;
    logic               fsm_in_valid;
    logic [STATE_W-1:0] fsm_state;
    logic [OUT_W-1:0]   fsm_out;

    modport master (
        output cpu_addr, cpu_data_in, cpu_write_enable, cpu_read_enable,
        output fsm_in, fsm_in_valid,
        input  cpu_data_out, cpu_rvalid, fsm_state, fsm_out
    );

    modport slave (
        input  cpu_addr, cpu_data_in, cpu_write_enable, cpu_read_enable,
        input  fsm_in, fsm_in_valid,
        output cpu_data_out, cpu_rvalid, fsm_state, fsm_out
    );
endinterface

// File: rtl/cpu_fsm_table_ctrl.sv
// Table-driven overlay FSM with a double-buffered (shadow/active) transition table
// programmed through a word-addressed CPU register map.
module cpu_fsm_table_ctrl #(
    parameter int STATE_W = 2,
    parameter int IN_W    = 2,
    parameter int OUT_W   = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    cpu_fsm_table_ctrl_if.slave  bus
);
    localparam int IDX_W = STATE_W + IN_W;
    localparam int DEPTH = 1 << IDX_W;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_IDX    = 3'd2;
    localparam logic [2:0] ADDR_DATA   = 3'd3;
    localparam logic [2:0] ADDR_TCOUNT = 3'd4;

    logic               r_run;
    logic [7:0]         r_rst_state;
    logic               r_step_pend;
    logic               r_commit_pend;
    logic               r_sreset_pend;
    logic               r_commit_done;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_tcount;
    logic [STATE_W-1:0] r_state;
    logic [OUT_W-1:0]   r_out;
    logic [31:0]        r_rdata;
    logic               r_rvalid;

    logic [STATE_W-1:0] r_sh_ns   [DEPTH];
    logic [OUT_W-1:0]   r_sh_out  [DEPTH];
    logic [STATE_W-1:0] r_act_ns  [DEPTH];
    logic [OUT_W-1:0]   r_act_out [DEPTH];

    logic               w_wr_ctrl;
    logic               w_wr_idx;
    logic               w_wr_data;
    logic               w_wr_tcount;
    logic               w_take;
    logic [IDX_W-1:0]   w_tidx;
    logic [31:0]        w_rdata;
    logic               w_unused_din;

    assign w_wr_ctrl    = bus.cpu_write_enable && (bus.cpu_addr == ADDR_CTRL);
    assign w_wr_idx     = bus.cpu_write_enable && (bus.cpu_addr == ADDR_IDX);
    assign w_wr_data    = bus.cpu_write_enable && (bus.cpu_addr == ADDR_DATA);
    assign w_wr_tcount  = bus.cpu_write_enable && (bus.cpu_addr == ADDR_TCOUNT);
    assign w_take       = (r_run && bus.fsm_in_valid) || r_step_pend;
    assign w_tidx       = {r_state, bus.fsm_in};
    assign w_unused_din = &{1'b0, bus.cpu_data_in};

    assign bus.cpu_data_out = r_rdata;
    assign bus.cpu_rvalid   = r_rvalid;
    assign bus.fsm_state    = r_state;
    assign bus.fsm_out      = r_out;

    // Read mux sees pre-edge contents, so a simultaneous write returns the old value.
    always_comb begin
        w_rdata = '0;
        case (bus.cpu_addr)
            ADDR_CTRL: begin
                w_rdata[0]    = r_run;
                w_rdata[15:8] = r_rst_state;
            end
            ADDR_STATUS: begin
                w_rdata[STATE_W-1:0] = r_state;
                w_rdata[8]           = r_run;
                w_rdata[9]           = r_commit_done;
            end
            ADDR_IDX:    w_rdata[IDX_W-1:0] = r_idx;
            ADDR_DATA: begin
                w_rdata[STATE_W-1:0] = r_sh_ns[r_idx];
                w_rdata[16 +: OUT_W] = r_sh_out[r_idx];
            end
            ADDR_TCOUNT: w_rdata = r_tcount;
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run         <= 1'b0;
            r_rst_state   <= '0;
            r_step_pend   <= 1'b0;
            r_commit_pend <= 1'b0;
            r_sreset_pend <= 1'b0;
            r_commit_done <= 1'b0;
            r_idx         <= '0;
            r_rdata       <= '0;
            r_rvalid      <= 1'b0;
        end else begin
            r_step_pend   <= 1'b0;
            r_commit_pend <= 1'b0;
            r_sreset_pend <= 1'b0;
            if (w_wr_ctrl) begin
                r_run         <= bus.cpu_data_in[0];
                r_step_pend   <= bus.cpu_data_in[1];
                r_commit_pend <= bus.cpu_data_in[2];
                r_sreset_pend <= bus.cpu_data_in[3];
                r_rst_state   <= bus.cpu_data_in[15:8];
                r_commit_done <= 1'b0;
            end
            // A commit completing on this edge outranks a concurrent CTRL-write clear.
            if (r_commit_pend) begin
                r_commit_done <= 1'b1;
            end
            if (w_wr_idx) begin
                r_idx <= bus.cpu_data_in[IDX_W-1:0];
            end else if (w_wr_data) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            r_rvalid <= bus.cpu_read_enable;
            if (bus.cpu_read_enable) begin
                r_rdata <= w_rdata;
            end
        end
    end

    // Commit copies the whole shadow table to active in a single edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sh_ns[i]   <= '0;
                r_sh_out[i]  <= '0;
                r_act_ns[i]  <= '0;
                r_act_out[i] <= '0;
            end
        end else begin
            if (w_wr_data) begin
                r_sh_ns[r_idx]  <= bus.cpu_data_in[STATE_W-1:0];
                r_sh_out[r_idx] <= bus.cpu_data_in[16 +: OUT_W];
            end
            if (r_commit_pend) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_act_ns[i]  <= r_sh_ns[i];
                    r_act_out[i] <= r_sh_out[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= '0;
            r_out    <= '0;
            r_tcount <= '0;
        end else begin
            if (r_sreset_pend) begin
                r_state <= r_rst_state[STATE_W-1:0];
                r_out   <= '0;
            end else if (w_take) begin
                r_state <= r_act_ns[w_tidx];
                r_out   <= r_act_out[w_tidx];
            end
            if (w_wr_tcount) begin
                r_tcount <= '0;
            end else if (w_take && !r_sreset_pend) begin
                r_tcount <= r_tcount + 32'd1;
            end
        end
    end
endmodule
